// File: rtl/mul21_compressor_tree.sv
// mul21_compressor_tree: bit-heap reducer for a 21x21 unsigned multiplier.
// 41 weighted columns (heights 1..21..1) are reduced by a Wallace tree of full
// and half adders to two rows, summed by a 42-bit adder and registered.
// Optional macro MUL21_COMPRESSOR_MID_PIPE_EN registers the two reduced rows
// ahead of the final adder, which raises latency from 1 to 2 cycles.
module mul21_compressor_tree (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:0]  src0,  input logic [1:0]  src1,  input logic [2:0]  src2,
  input  logic [3:0]  src3,  input logic [4:0]  src4,  input logic [5:0]  src5,
  input  logic [6:0]  src6,  input logic [7:0]  src7,  input logic [8:0]  src8,
  input  logic [9:0]  src9,  input logic [10:0] src10, input logic [11:0] src11,
  input  logic [12:0] src12, input logic [13:0] src13, input logic [14:0] src14,
  input  logic [15:0] src15, input logic [16:0] src16, input logic [17:0] src17,
  input  logic [18:0] src18, input logic [19:0] src19, input logic [20:0] src20,
  input  logic [19:0] src21, input logic [18:0] src22, input logic [17:0] src23,
  input  logic [16:0] src24, input logic [15:0] src25, input logic [14:0] src26,
  input  logic [13:0] src27, input logic [12:0] src28, input logic [11:0] src29,
  input  logic [10:0] src30, input logic [9:0]  src31, input logic [8:0]  src32,
  input  logic [7:0]  src33, input logic [6:0]  src34, input logic [5:0]  src35,
  input  logic [4:0]  src36, input logic [3:0]  src37, input logic [2:0]  src38,
  input  logic [1:0]  src39, input logic [0:0]  src40,
  output logic dst0,  output logic dst1,  output logic dst2,  output logic dst3,
  output logic dst4,  output logic dst5,  output logic dst6,  output logic dst7,
  output logic dst8,  output logic dst9,  output logic dst10, output logic dst11,
  output logic dst12, output logic dst13, output logic dst14, output logic dst15,
  output logic dst16, output logic dst17, output logic dst18, output logic dst19,
  output logic dst20, output logic dst21, output logic dst22, output logic dst23,
  output logic dst24, output logic dst25, output logic dst26, output logic dst27,
  output logic dst28, output logic dst29, output logic dst30, output logic dst31,
  output logic dst32, output logic dst33, output logic dst34, output logic dst35,
  output logic dst36, output logic dst37, output logic dst38, output logic dst39,
  output logic dst40, output logic dst41
);

  localparam int NCOL   = 42;
  localparam int MAXH   = 22;
  // Wallace needs 7 levels for height 21; spare levels become plain copies.
  localparam int LEVELS = 10;

  logic [MAXH-1:0] col_in   [NCOL];
  logic [MAXH-1:0] heap_cur [NCOL];
  logic [MAXH-1:0] heap_nxt [NCOL];
  int              h_cur    [NCOL];
  int              h_nxt    [NCOL];
  int              n_fa;
  int              rem_base;
  logic            reduce_en;
  logic [NCOL-1:0] row_a, row_b, sum_w, res_q;

  assign col_in[0]  = MAXH'(src0);  assign col_in[1]  = MAXH'(src1);  assign col_in[2]  = MAXH'(src2);
  assign col_in[3]  = MAXH'(src3);  assign col_in[4]  = MAXH'(src4);  assign col_in[5]  = MAXH'(src5);
  assign col_in[6]  = MAXH'(src6);  assign col_in[7]  = MAXH'(src7);  assign col_in[8]  = MAXH'(src8);
  assign col_in[9]  = MAXH'(src9);  assign col_in[10] = MAXH'(src10); assign col_in[11] = MAXH'(src11);
  assign col_in[12] = MAXH'(src12); assign col_in[13] = MAXH'(src13); assign col_in[14] = MAXH'(src14);
  assign col_in[15] = MAXH'(src15); assign col_in[16] = MAXH'(src16); assign col_in[17] = MAXH'(src17);
  assign col_in[18] = MAXH'(src18); assign col_in[19] = MAXH'(src19); assign col_in[20] = MAXH'(src20);
  assign col_in[21] = MAXH'(src21); assign col_in[22] = MAXH'(src22); assign col_in[23] = MAXH'(src23);
  assign col_in[24] = MAXH'(src24); assign col_in[25] = MAXH'(src25); assign col_in[26] = MAXH'(src26);
  assign col_in[27] = MAXH'(src27); assign col_in[28] = MAXH'(src28); assign col_in[29] = MAXH'(src29);
  assign col_in[30] = MAXH'(src30); assign col_in[31] = MAXH'(src31); assign col_in[32] = MAXH'(src32);
  assign col_in[33] = MAXH'(src33); assign col_in[34] = MAXH'(src34); assign col_in[35] = MAXH'(src35);
  assign col_in[36] = MAXH'(src36); assign col_in[37] = MAXH'(src37); assign col_in[38] = MAXH'(src38);
  assign col_in[39] = MAXH'(src39); assign col_in[40] = MAXH'(src40); assign col_in[41] = '0;

  // Wallace reduction. Column heights depend only on geometry, so every loop
  // bound and index below folds to a constant and the result is a fixed
  // adder network. Carries out of column 41 are dropped: the heap total is
  // below 2^42, so they are always zero.
  always_comb begin
    n_fa      = 0;
    rem_base  = 0;
    reduce_en = 1'b0;
    row_a     = '0;
    row_b     = '0;
    for (int c = 0; c < NCOL; c++) begin
      heap_cur[c] = col_in[c];
      heap_nxt[c] = '0;
      h_cur[c]    = (c > 40) ? 0 : (((c < 40 - c) ? c : 40 - c) + 1);
      h_nxt[c]    = 0;
    end
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      reduce_en = 1'b0;
      for (int c = 0; c < NCOL; c++) begin
        if (h_cur[c] > 2) reduce_en = 1'b1;
      end
      if (reduce_en) begin
        for (int c = 0; c < NCOL; c++) begin
          heap_nxt[c] = '0;
          h_nxt[c]    = 0;
        end
        for (int c = 0; c < NCOL; c++) begin
          n_fa     = h_cur[c] / 3;
          rem_base = 3 * n_fa;
          for (int k = 0; k < 7; k++) begin
            if (k < n_fa) begin
              heap_nxt[c][h_nxt[c]] = heap_cur[c][3*k] ^ heap_cur[c][3*k+1] ^ heap_cur[c][3*k+2];
              h_nxt[c] = h_nxt[c] + 1;
              if (c + 1 < NCOL) begin
                heap_nxt[c+1][h_nxt[c+1]] = (heap_cur[c][3*k] & heap_cur[c][3*k+1]) |
                                            (heap_cur[c][3*k] & heap_cur[c][3*k+2]) |
                                            (heap_cur[c][3*k+1] & heap_cur[c][3*k+2]);
                h_nxt[c+1] = h_nxt[c+1] + 1;
              end
            end
          end
          if (h_cur[c] - rem_base == 2) begin
            heap_nxt[c][h_nxt[c]] = heap_cur[c][rem_base] ^ heap_cur[c][rem_base+1];
            h_nxt[c] = h_nxt[c] + 1;
            if (c + 1 < NCOL) begin
              heap_nxt[c+1][h_nxt[c+1]] = heap_cur[c][rem_base] & heap_cur[c][rem_base+1];
              h_nxt[c+1] = h_nxt[c+1] + 1;
            end
          end else if (h_cur[c] - rem_base == 1) begin
            heap_nxt[c][h_nxt[c]] = heap_cur[c][rem_base];
            h_nxt[c] = h_nxt[c] + 1;
          end
        end
        for (int c = 0; c < NCOL; c++) begin
          heap_cur[c] = heap_nxt[c];
          h_cur[c]    = h_nxt[c];
        end
      end
    end
    for (int c = 0; c < NCOL; c++) begin
      row_a[c] = heap_cur[c][0];
      row_b[c] = heap_cur[c][1];
    end
  end

`ifdef MUL21_COMPRESSOR_MID_PIPE_EN
  logic [NCOL-1:0] row_a_q, row_b_q;

  // Split the tree and the carry-propagate adder into separate cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_a_q <= '0;
      row_b_q <= '0;
    end else begin
      row_a_q <= row_a;
      row_b_q <= row_b;
    end
  end

  assign sum_w = row_a_q + row_b_q;
`else
  assign sum_w = row_a + row_b;
`endif

  // Output register; reset wins over incoming data.
  always_ff @(posedge clk) begin
    if (rst) res_q <= '0;
    else     res_q <= sum_w;
  end

  assign dst0  = res_q[0];  assign dst1  = res_q[1];  assign dst2  = res_q[2];  assign dst3  = res_q[3];
  assign dst4  = res_q[4];  assign dst5  = res_q[5];  assign dst6  = res_q[6];  assign dst7  = res_q[7];
  assign dst8  = res_q[8];  assign dst9  = res_q[9];  assign dst10 = res_q[10]; assign dst11 = res_q[11];
  assign dst12 = res_q[12]; assign dst13 = res_q[13]; assign dst14 = res_q[14]; assign dst15 = res_q[15];
  assign dst16 = res_q[16]; assign dst17 = res_q[17]; assign dst18 = res_q[18]; assign dst19 = res_q[19];
  assign dst20 = res_q[20]; assign dst21 = res_q[21]; assign dst22 = res_q[22]; assign dst23 = res_q[23];
  assign dst24 = res_q[24]; assign dst25 = res_q[25]; assign dst26 = res_q[26]; assign dst27 = res_q[27];
  assign dst28 = res_q[28]; assign dst29 = res_q[29]; assign dst30 = res_q[30]; assign dst31 = res_q[31];
  assign dst32 = res_q[32]; assign dst33 = res_q[33]; assign dst34 = res_q[34]; assign dst35 = res_q[35];
  assign dst36 = res_q[36]; assign dst37 = res_q[37]; assign dst38 = res_q[38]; assign dst39 = res_q[39];
  assign dst40 = res_q[40]; assign dst41 = res_q[41];

endmodule

// File: tb/tb_mul21_compressor_tree.sv
// Scoreboard bench for mul21_compressor_tree. The driver pushes one expected
// entry per applied cycle; a monitor models the output latency and reset
// flush, then compares dst each cycle. Honours MUL21_COMPRESSOR_MID_PIPE_EN.
module tb_mul21_compressor_tree;

`ifdef MUL21_COMPRESSOR_MID_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic        vld;
    logic        rst;
    logic [41:0] val;
    logic [15:0] tag;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [20:0] col   [41];
  logic [20:0] stage [41];
  wire  [41:0] dst;
  sb_t         sb_q [$];
  string       names [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mul21_compressor_tree dut (
    .clk(clk), .rst(rst),
    .src0(col[0][0:0]),   .src1(col[1][1:0]),   .src2(col[2][2:0]),   .src3(col[3][3:0]),
    .src4(col[4][4:0]),   .src5(col[5][5:0]),   .src6(col[6][6:0]),   .src7(col[7][7:0]),
    .src8(col[8][8:0]),   .src9(col[9][9:0]),   .src10(col[10][10:0]), .src11(col[11][11:0]),
    .src12(col[12][12:0]), .src13(col[13][13:0]), .src14(col[14][14:0]), .src15(col[15][15:0]),
    .src16(col[16][16:0]), .src17(col[17][17:0]), .src18(col[18][18:0]), .src19(col[19][19:0]),
    .src20(col[20][20:0]), .src21(col[21][19:0]), .src22(col[22][18:0]), .src23(col[23][17:0]),
    .src24(col[24][16:0]), .src25(col[25][15:0]), .src26(col[26][14:0]), .src27(col[27][13:0]),
    .src28(col[28][12:0]), .src29(col[29][11:0]), .src30(col[30][10:0]), .src31(col[31][9:0]),
    .src32(col[32][8:0]),  .src33(col[33][7:0]),  .src34(col[34][6:0]),  .src35(col[35][5:0]),
    .src36(col[36][4:0]),  .src37(col[37][3:0]),  .src38(col[38][2:0]),  .src39(col[39][1:0]),
    .src40(col[40][0:0]),
    .dst0(dst[0]),   .dst1(dst[1]),   .dst2(dst[2]),   .dst3(dst[3]),   .dst4(dst[4]),
    .dst5(dst[5]),   .dst6(dst[6]),   .dst7(dst[7]),   .dst8(dst[8]),   .dst9(dst[9]),
    .dst10(dst[10]), .dst11(dst[11]), .dst12(dst[12]), .dst13(dst[13]), .dst14(dst[14]),
    .dst15(dst[15]), .dst16(dst[16]), .dst17(dst[17]), .dst18(dst[18]), .dst19(dst[19]),
    .dst20(dst[20]), .dst21(dst[21]), .dst22(dst[22]), .dst23(dst[23]), .dst24(dst[24]),
    .dst25(dst[25]), .dst26(dst[26]), .dst27(dst[27]), .dst28(dst[28]), .dst29(dst[29]),
    .dst30(dst[30]), .dst31(dst[31]), .dst32(dst[32]), .dst33(dst[33]), .dst34(dst[34]),
    .dst35(dst[35]), .dst36(dst[36]), .dst37(dst[37]), .dst38(dst[38]), .dst39(dst[39]),
    .dst40(dst[40]), .dst41(dst[41])
  );

  function automatic int hgt(input int i);
    return ((i < 40 - i) ? i : 40 - i) + 1;
  endfunction

  task automatic clear_stage();
    for (int i = 0; i < 41; i++) stage[i] = '0;
  endtask

  task automatic ones_stage();
    for (int i = 0; i < 41; i++) stage[i] = 21'((1 << hgt(i)) - 1);
  endtask

  // Partial product a_k & b_m lands in column k+m.
  task automatic pp_stage(input logic [20:0] a, input logic [20:0] b);
    int c;
    int idx;
    clear_stage();
    for (int k = 0; k < 21; k++) begin
      for (int m = 0; m < 21; m++) begin
        if (a[k] && b[m]) begin
          c   = k + m;
          idx = k - ((c > 20) ? c - 20 : 0);
          stage[c][idx] = 1'b1;
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic [41:0] exp, input string nm);
    sb_t e;
    @(negedge clk);
    rst = r;
    for (int i = 0; i < 41; i++) col[i] = stage[i];
    names.push_back(nm);
    e.vld = 1'b1;
    e.rst = r;
    e.val = r ? 42'd0 : exp;
    e.tag = 16'(names.size() - 1);
    sb_q.push_back(e);
  endtask

  // Monitor: one scoreboard entry per clock edge; reset flushes the model pipe.
  initial begin : monitor
    sb_t pipe [LAT];
    sb_t e;
    for (int i = 0; i < LAT; i++) pipe[i] = '0;
    forever begin
      @(posedge clk);
      if (sb_q.size() > 0) e = sb_q.pop_front();
      else                 e = '0;
      if (e.rst) begin
        for (int i = 0; i < LAT; i++) pipe[i] = e;
      end else begin
        for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = e;
      end
      #1;
      if (pipe[LAT-1].vld) begin
        checks++;
        if (dst !== pipe[LAT-1].val) begin
          errors++;
          $display("FAIL %s: dst=0x%011h expected 0x%011h", names[pipe[LAT-1].tag], dst, pipe[LAT-1].val);
        end
      end
    end
  end

  initial begin : driver
    logic [20:0] a, b;
    rst = 1'b1;
    for (int i = 0; i < 41; i++) col[i] = '0;

    ones_stage();
    drive(1'b1, 42'd0, "rst_hold_a");
    drive(1'b1, 42'd0, "rst_hold_b");

    clear_stage();                 drive(1'b0, 42'd0,               "all_zero");
    clear_stage(); stage[0]  = 1;  drive(1'b0, 42'd1,               "src0_only");
    clear_stage(); stage[40] = 1;  drive(1'b0, 42'h100_0000_0000,   "src40_only");
    ones_stage();                  drive(1'b0, 42'h3FF_FFC0_0001,   "all_ones");
    clear_stage(); stage[20] = 21'h1F_FFFF;
                                   drive(1'b0, 42'h150_0000,        "src20_full");
    pp_stage(21'd3, 21'd5);        drive(1'b0, 42'd15,              "pp_3x5");
    clear_stage(); stage[1]  = 21'b11;
                                   drive(1'b0, 42'd4,               "src1_two");
    pp_stage(21'h1F_FFFF, 21'd1);  drive(1'b0, 42'h1F_FFFF,         "pp_max_x1");
    pp_stage(21'd12345, 21'd678);  drive(1'b0, 42'd8369910,         "pp_12345x678");
    pp_stage(21'h10_0000, 21'h10_0000);
                                   drive(1'b0, 42'h100_0000_0000,   "pp_msb_sq");

    for (int i = 0; i < 24; i++) begin
      a = 21'($urandom_range(0, 21'h1F_FFFF));
      b = 21'($urandom_range(0, 21'h1F_FFFF));
      pp_stage(a, b);
      drive((i == 10 || i == 11), {21'd0, a} * {21'd0, b}, $sformatf("stream%0d", i));
    end

    repeat (LAT + 3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: left=%0d expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
